// File: rtl/act_stream_driver.sv
// act_stream_driver: initiator side of the activation-unit start/ready/done
// handshake. Streams LEN words from a source scratch buffer through an
// activation unit and writes each result into a destination buffer.
module act_stream_driver #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  // command interface
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              cmd_done,
  output logic              cmd_error,
  output logic [LEN_W-1:0]  elem_count,
  // source memory (1-cycle synchronous read)
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  // destination memory
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  // activation unit handshake
  output logic              act_start,
  output logic [DATA_W-1:0] act_data,
  input  logic              act_ready,
  input  logic              act_done,
  input  logic [DATA_W-1:0] act_result
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_ISSUE,
    S_WAIT_DONE,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  // Elements completed so far; doubles as the index of the element in flight.
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] act_data_q, act_data_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic              tmo_hit;
  logic [LEN_W-1:0]  cnt_inc;

  // tmo_q counts cycles already spent in ISSUE/WAIT_DONE for this element,
  // so the current cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign cnt_inc = cnt_q + LEN_W'(1);

  // State and datapath registers; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      act_data_q <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      act_data_q <= act_data_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic and the strobes, which depend only on state (and
  // act_ready / timeout in ISSUE), so they can never overlap.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    act_data_d = act_data_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    act_start  = 1'b0;
    cmd_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          len_d   = cmd_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (cmd_len == '0) ? S_FINISH : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        rd_en   = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        act_data_d = rd_data;
        tmo_d      = '0;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (act_ready) begin
            act_start = 1'b1;
            state_d   = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        // A result arriving on the last allowed cycle still counts.
        if (act_done) begin
          wr_data_d = act_result;
          state_d   = S_WRITE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? S_FINISH : S_RD_REQ;
      end
      S_FINISH: begin
        cmd_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses wrap naturally at 2^ADDR_W.
  assign rd_addr    = src_q + ADDR_W'(cnt_q);
  assign wr_addr    = dst_q + ADDR_W'(cnt_q);
  assign wr_data    = wr_data_q;
  assign act_data   = act_data_q;
  assign busy       = (state_q != S_IDLE);
  assign cmd_error  = err_q;
  assign elem_count = cnt_q;

endmodule

// File: tb/tb_act_stream_driver.sv
// Bench for act_stream_driver: source RAM, a relu6-style 3-cycle activation
// unit (optionally a stub that never finishes), a table of command vectors,
// and a hand-written asynchronous-reset sequence.
module tb_act_stream_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [15:0] cmd_src = '0, cmd_dst = '0, cmd_len = '0;
  logic        busy, cmd_done, cmd_error;
  logic [15:0] elem_count;
  logic        rd_en, wr_en, act_start, act_ready, act_done;
  logic [15:0] rd_addr, wr_addr;
  logic [31:0] rd_data = '0, wr_data, act_data, act_result;

  act_stream_driver #(.ADDR_W(16), .DATA_W(32), .LEN_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_start(cmd_start), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .busy(busy), .cmd_done(cmd_done), .cmd_error(cmd_error), .elem_count(elem_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .act_start(act_start), .act_data(act_data), .act_ready(act_ready),
    .act_done(act_done), .act_result(act_result)
  );

  always #5 clk = ~clk;

  // ---------------- environment ----------------
  logic [31:0] src_mem [0:65535];
  logic [15:0] rd_log [$];
  logic [15:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  int          st_total = 0, done_total = 0, overlap_cnt = 0;
  logic        stub_mode = 1'b0, force_low = 1'b0;
  logic [2:0]  ucnt;
  logic [31:0] uop;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= src_mem[rd_addr];
      rd_log.push_back(rd_addr);
    end
    if (wr_en) begin
      wr_addr_log.push_back(wr_addr);
      wr_data_log.push_back(wr_data);
    end
    if (act_start) st_total <= st_total + 1;
    if (cmd_done) done_total <= done_total + 1;
  end

  always @(negedge clk)
    if (int'(rd_en) + int'(wr_en) + int'(act_start) > 1) overlap_cnt <= overlap_cnt + 1;

  // Activation unit: start sampled at edge t, done high so it is sampled at t+3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt <= '0;
      uop  <= '0;
    end else if (act_start && act_ready) begin
      ucnt <= 3'd3;
      uop  <= act_data;
    end else if (ucnt != 0) begin
      ucnt <= ucnt - 3'd1;
    end
  end
  assign act_ready  = !force_low && (stub_mode || ucnt == 0);
  assign act_done   = !stub_mode && ucnt == 3'd1;
  assign act_result = ($signed(uop) < 0) ? 32'd0 : ($signed(uop) > 6) ? 32'd6 : uop;

  // ---------------- checking ----------------
  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] src, dst, len;
    logic [31:0] din  [4];
    logic [31:0] dout [4];
    int          hold;   // act_ready forced low until this sample index
    logic        stub;   // unit never signals done
    logic        poke;   // extra cmd_start while busy
    int          exp_cnt;
    logic        exp_err;
    int          exp_lat; // cycles from cmd_start edge to cmd_done sample
  } vec_t;

  vec_t vec [7];

  task automatic run_vec(input int v);
    int rd0, wr0, st0, cyc, exp_rd;
    logic [15:0] a;
    rd0 = rd_log.size(); wr0 = wr_addr_log.size(); st0 = st_total;
    for (int i = 0; i < int'(vec[v].len); i++) begin
      a = vec[v].src + 16'(i);
      src_mem[a] = vec[v].din[i];
    end
    stub_mode = vec[v].stub;
    force_low = (vec[v].hold != 0);
    @(negedge clk);
    cmd_src = vec[v].src; cmd_dst = vec[v].dst; cmd_len = vec[v].len; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    cyc = 1;
    check($sformatf("v%0d_busy_after_accept", v), busy, 1);
    while (!cmd_done && cyc < 400) begin
      if (cyc >= vec[v].hold) force_low = 1'b0;
      if (vec[v].poke && cyc == 5) begin
        cmd_start = 1'b1; cmd_src = 16'h7777; cmd_dst = 16'h7777; cmd_len = 16'd1;
      end else begin
        cmd_start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cmd_start = 1'b0;
    force_low = 1'b0;
    $display("vec %0d: src=%h dst=%h len=%0d latency=%0d count=%0d err=%0b",
             v, vec[v].src, vec[v].dst, vec[v].len, cyc, elem_count, cmd_error);
    check($sformatf("v%0d_latency", v), cyc, vec[v].exp_lat);
    check($sformatf("v%0d_cmd_error", v), cmd_error, vec[v].exp_err);
    check($sformatf("v%0d_elem_count", v), elem_count, vec[v].exp_cnt);
    exp_rd = vec[v].exp_err ? 1 : int'(vec[v].len);
    check($sformatf("v%0d_rd_count", v), rd_log.size() - rd0, exp_rd);
    check($sformatf("v%0d_start_count", v), st_total - st0, exp_rd);
    check($sformatf("v%0d_wr_count", v), wr_addr_log.size() - wr0, vec[v].exp_cnt);
    for (int i = 0; i < exp_rd && rd0 + i < rd_log.size(); i++) begin
      a = vec[v].src + 16'(i);
      check($sformatf("v%0d_rd_addr%0d", v, i), rd_log[rd0 + i], a);
    end
    for (int i = 0; i < vec[v].exp_cnt && wr0 + i < wr_addr_log.size(); i++) begin
      a = vec[v].dst + 16'(i);
      check($sformatf("v%0d_wr_addr%0d", v, i), wr_addr_log[wr0 + i], a);
      check($sformatf("v%0d_wr_data%0d", v, i), wr_data_log[wr0 + i], vec[v].dout[i]);
    end
    @(posedge clk); #1;
    check($sformatf("v%0d_busy_after_done", v), busy, 0);
    check($sformatf("v%0d_done_one_cycle", v), cmd_done, 0);
  endtask

  initial begin
    int k;
    int d0;
    // src, dst, len, din, dout, hold, stub, poke, cnt, err, latency
    vec[0] = '{16'h0100, 16'h0200, 16'd4, '{32'hFFFF_FFFD, 32'd2, 32'd9, 32'd6},
               '{32'd0, 32'd2, 32'd6, 32'd6}, 0, 1'b0, 1'b0, 4, 1'b0, 29};
    vec[1] = '{16'h0300, 16'h0400, 16'd0, '{32'd0, 32'd0, 32'd0, 32'd0},
               '{32'd0, 32'd0, 32'd0, 32'd0}, 0, 1'b0, 1'b0, 0, 1'b0, 1};
    vec[2] = '{16'h0500, 16'h0600, 16'd2, '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0},
               '{32'd6, 32'd0, 32'd0, 32'd0}, 6, 1'b0, 1'b0, 2, 1'b0, 18};
    vec[3] = '{16'h0700, 16'h0800, 16'd3, '{32'd1, 32'd2, 32'd3, 32'd0},
               '{32'd0, 32'd0, 32'd0, 32'd0}, 0, 1'b1, 1'b0, 0, 1'b1, 18};
    vec[4] = '{16'hFFFE, 16'hFFFF, 16'd3, '{32'd5, 32'd0, 32'h8000_0000, 32'd0},
               '{32'd5, 32'd0, 32'd0, 32'd0}, 0, 1'b0, 1'b0, 3, 1'b0, 22};
    vec[5] = '{16'h0A00, 16'h0B00, 16'd1, '{32'd3, 32'd0, 32'd0, 32'd0},
               '{32'd3, 32'd0, 32'd0, 32'd0}, 0, 1'b0, 1'b0, 1, 1'b0, 8};
    vec[6] = '{16'h0900, 16'h0C00, 16'd4, '{32'd4, 32'hFFFF_FF00, 32'd100, 32'd1},
               '{32'd4, 32'd0, 32'd6, 32'd1}, 0, 1'b0, 1'b1, 4, 1'b0, 29};

    // Reset state
    #1;
    check("reset_strobes", {busy, cmd_done, cmd_error, rd_en, wr_en, act_start}, 0);
    check("reset_elem_count", elem_count, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(v);

    // Asynchronous reset in WAIT_DONE of the second element
    for (int i = 0; i < 4; i++) src_mem[16'h0D00 + 16'(i)] = 32'd1;
    @(negedge clk);
    cmd_src = 16'h0D00; cmd_dst = 16'h0E00; cmd_len = 16'd4; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    k = 0;
    while (!(elem_count == 16'd1 && act_start) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_reached_elem2_issue", k < 200, 1);
    @(posedge clk); #2;
    d0 = done_total;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted: busy=%0b elem_count=%0d", busy, elem_count);
    check("rst_strobes", {busy, cmd_done, cmd_error, rd_en, wr_en, act_start}, 0);
    check("rst_elem_count", elem_count, 0);
    check("rst_act_data", act_data, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_cmd_done", done_total - d0, 0);

    // New command after reset, with an ignored cmd_start while busy
    run_vec(6);

    check("strobe_overlap", overlap_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/act_stream_driver.md
Name: act_stream_driver

Overview:
- Initiator side of the activation-unit start/ready/done handshake.
- Reads LEN words from a source buffer, issues each word to an activation unit (e.g. relu6_unit), and writes each result to a destination buffer.
- Sits between the layer controller (command interface) and the on-chip scratch memories.
- Reports completion, element count and handshake timeout to the controller.

Parameters:
- ADDR_W, 16, scratch memory address width.
- DATA_W, 32, data word width; must equal the activation unit width.
- LEN_W, 16, element-count width.
- TIMEOUT, 15, max cycles spent in ISSUE+WAIT_DONE per element before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_start  in  1  one-cycle command pulse, accepted only in IDLE.
- cmd_src  in  ADDR_W  source base address.
- cmd_dst  in  ADDR_W  destination base address.
- cmd_len  in  LEN_W  number of elements.
- busy  out  1  high from command accept until FINISH.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_error  out  1  valid with cmd_done: 1 = aborted on timeout.
- elem_count  out  LEN_W  elements written for the current or last command.
- rd_en  out  1  source memory read strobe.
- rd_addr  out  ADDR_W  source read address.
- rd_data  in  DATA_W  read data, valid the cycle after rd_en (1-cycle synchronous RAM).
- wr_en  out  1  destination write strobe.
- wr_addr  out  ADDR_W  destination write address.
- wr_data  out  DATA_W  write data.
- act_start  out  1  start pulse to the activation unit.
- act_data  out  DATA_W  operand to the activation unit.
- act_ready  in  1  activation unit idle.
- act_done  in  1  activation unit result pulse.
- act_result  in  DATA_W  activation unit result, valid while act_done=1.

Behaviour:
- Reset: asynchronous. All outputs go to 0 immediately, including act_start, rd_en and wr_en. FSM returns to IDLE. An in-flight command is discarded without a cmd_done pulse.
- States: IDLE, RD_REQ, RD_WAIT, ISSUE, WAIT_DONE, WRITE, FINISH.
- IDLE:
  - On cmd_start, latch src/dst/len and clear elem_count.
  - If len=0, go to FINISH (cmd_done one cycle after accept, no memory or unit traffic).
  - Otherwise go to RD_REQ with busy=1.
  - cmd_start while not in IDLE is ignored.
- RD_REQ: rd_en=1, rd_addr = src + index.
- RD_WAIT: capture rd_data into the act_data register. act_data then stays stable through ISSUE and WAIT_DONE.
- ISSUE: assert act_start=1 for exactly one cycle, in the first cycle act_ready=1, then go to WAIT_DONE. While act_ready=0, hold act_start=0 and stay in ISSUE.
- WAIT_DONE: on act_done=1, register act_result into wr_data and go to WRITE. act_done is treated as a pulse; only the first one is used.
- WRITE:
  - wr_en=1, wr_addr = dst + index; increment elem_count and index.
  - If index+1 = len, go to FINISH, else go to RD_REQ.
- FINISH: cmd_done=1 for one cycle, cmd_error as latched, busy=0 from the next cycle, return to IDLE.
- Timeout:
  - A per-element counter clears on entry to ISSUE and increments each cycle in ISSUE and WAIT_DONE.
  - On reaching TIMEOUT, deassert act_start, latch cmd_error=1 and go to FINISH. Remaining elements are not processed; elem_count holds the number completed.
  - cmd_error clears on the next accepted command.
- Latency with a 3-cycle unit (start sampled at edge t, done high at t+3): 7 cycles per element. cmd_done arrives 7·len+1 cycles after the cmd_start edge.
- Addresses wrap modulo 2^ADDR_W; no error is raised on wrap.
- An act_done that arrives outside WAIT_DONE is ignored.
- Strobe exclusivity: rd_en, wr_en and act_start are never high in the same cycle.

Test Plan:
- Nominal, with relu6_unit attached: src words {−3, 2, 9, 6}, len=4 → dst gets {0, 2, 6, 6}; elem_count=4; cmd_done after 29 cycles; cmd_error=0.
- len=0 → cmd_done 1 cycle after accept; no rd_en, wr_en or act_start ever asserted.
- act_ready held low for 5 cycles before the first element → act_start fires only once act_ready is high; results are correct; no error.
- Stub unit that never asserts act_done, TIMEOUT=15, len=3 → cmd_error=1 with cmd_done on cycle 15 of the first element; elem_count=0; wr_en never asserted.
- src=0xFFFE, dst=0xFFFF, len=3 → reads 0xFFFE, 0xFFFF, 0x0000; writes 0xFFFF, 0x0000, 0x0001.
- rst_n pulsed low during WAIT_DONE of element 2 → outputs 0 immediately, no cmd_done. A new command after reset completes normally. A second cmd_start while busy is ignored.
